// File: rtl/fifo_wr_sched.sv
// Write-side scheduler for the async FIFO. It arbitrates requesters onto the write port
// and grants a burst only after reserving free space for every word of it.
module fifo_wr_sched #(
  parameter int ADDRSIZE = 4,
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int LENW     = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LENW-1:0]    req_len,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         req_ack,
  input  logic [ADDRSIZE:0]       wq2_rptr,
  output logic                    winc,
  output logic [ADDRSIZE-1:0]     waddr,
  output logic [DSIZE-1:0]        wdata,
  output logic [ADDRSIZE:0]       wptr,
  output logic                    wfull,
  output logic [ADDRSIZE:0]       wfree
);

  localparam int PW = ADDRSIZE + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;
  localparam int CW = ((LENW > ADDRSIZE) ? LENW : ADDRSIZE) + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wbin_q, wbin_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [LENW-1:0]   cnt_q, cnt_d;
  logic              wfull_q, wfull_d;
  logic [PW-1:0]     wfree_q, wfree_d;

  logic [LENW-1:0]   len_a  [NREQ];
  logic [DSIZE-1:0]  data_a [NREQ];
  logic [PW-1:0]     rbin;

  logic              cand_found;
  logic [IW-1:0]     cand_idx;
  logic [SW-1:0]     scan_idx;
  logic [LENW-1:0]   cand_len;
  logic [PW-1:0]     free_now;
  logic [CW-1:0]     need;
  logic              fits;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign len_a[gi]  = req_len[gi*LENW +: LENW];
    assign data_a[gi] = req_data[gi*DSIZE +: DSIZE];
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
    assign rbin[gi] = ^wq2_rptr[ADDRSIZE:gi];
  end

  // Round-robin scan starting at rr; the first asserted request is head-of-line.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_q} + SW'(k);
      if (scan_idx >= SW'(NREQ)) begin
        scan_idx = scan_idx - SW'(NREQ);
      end
      if (!cand_found && req[scan_idx[IW-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx[IW-1:0];
      end
    end
  end

  assign cand_len = len_a[cand_idx];
  assign free_now = DEPTH - (wbin_q - rbin);
  assign need     = CW'(cand_len) + CW'(1);
  assign fits     = (CW'(free_now) >= need);

  assign winc    = (state_q == BURST) && req_valid[gidx_q];
  assign req_ack = winc ? gnt_q : '0;
  assign wdata   = data_a[gidx_q];
  assign waddr   = wbin_q[ADDRSIZE-1:0];
  assign gnt     = gnt_q;
  assign wptr    = wptr_q;
  assign wfull   = wfull_q;
  assign wfree   = wfree_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cand_found && fits) begin
          state_d = BURST;
          gnt_d   = NREQ'(1) << cand_idx;
          gidx_d  = cand_idx;
          cnt_d   = cand_len;
        end
      end
      BURST: begin
        if (winc) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            gnt_d   = '0;
            rr_d    = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
          end else begin
            cnt_d = cnt_q - LENW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Space flags follow the post-write pointer so they are exact the cycle after a write.
  always_comb begin
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, winc};
    wptr_d  = wbin_d ^ (wbin_d >> 1);
    wfree_d = DEPTH - (wbin_d - rbin);
    wfull_d = (wfree_d == '0);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      wbin_q  <= '0;
      wptr_q  <= '0;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      wfull_q <= 1'b0;
      wfree_q <= DEPTH;
    end else begin
      state_q <= state_d;
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wfull_q <= wfull_d;
      wfree_q <= wfree_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Self-checking bench for fifo_wr_sched: expected writes are queued as stimulus is
// driven and compared by a monitor whenever the DUT asserts winc.
module tb_fifo_wr_sched;

  localparam int ADDRSIZE = 4;
  localparam int DSIZE    = 8;
  localparam int NREQ     = 4;
  localparam int LENW     = 4;
  localparam int PW       = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH = 5'd16;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*LENW-1:0]  req_len;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       req_ack;
  logic [ADDRSIZE:0]     wq2_rptr;
  logic                  winc;
  logic [ADDRSIZE-1:0]   waddr;
  logic [DSIZE-1:0]      wdata;
  logic [ADDRSIZE:0]     wptr;
  logic                  wfull;
  logic [ADDRSIZE:0]     wfree;

  fifo_wr_sched #(
    .ADDRSIZE(ADDRSIZE), .DSIZE(DSIZE), .NREQ(NREQ), .LENW(LENW)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_len(req_len),
    .req_valid(req_valid), .req_data(req_data), .gnt(gnt), .req_ack(req_ack),
    .wq2_rptr(wq2_rptr), .winc(winc), .waddr(waddr), .wdata(wdata),
    .wptr(wptr), .wfull(wfull), .wfree(wfree)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [ADDRSIZE-1:0] addr;
    logic [DSIZE-1:0]    data;
    logic [NREQ-1:0]     ack;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            winc_count = 0;
  logic [PW-1:0] m_wbin = '0;
  logic [PW-1:0] m_rbin = '0;
  logic [7:0]    data_seq = 8'h01;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] m_free();
    return DEPTH - (m_wbin - m_rbin);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Write monitor: every winc must match the oldest queued expectation.
  always @(negedge wclk) begin
    wr_t e;
    if (wrst_n === 1'b1 && winc === 1'b1) begin
      winc_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%02h ack=%b exp no write", waddr, wdata, req_ack);
      end else begin
        e = exp_q.pop_front();
        $display("write addr=%0d data=%02h ack=%b", waddr, wdata, req_ack);
        if (waddr !== e.addr || wdata !== e.data || req_ack !== e.ack) begin
          failures++;
          $display("FAIL write got addr=%0d data=%02h ack=%b exp addr=%0d data=%02h ack=%b",
                   waddr, wdata, req_ack, e.addr, e.data, e.ack);
        end
      end
      checks++;
      if (wfull !== 1'b0) begin
        failures++;
        $display("FAIL write_while_full got wfull=%b exp 0", wfull);
      end
    end
  end

  task automatic do_reset();
    wrst_n    = 1'b0;
    req       = '0;
    req_len   = '0;
    req_valid = '0;
    req_data  = '0;
    wq2_rptr  = '0;
    tick();
    tick();
    wrst_n = 1'b1;
    m_wbin = '0;
    m_rbin = '0;
    exp_q.delete();
    tick();
  endtask

  // Expects a grant at the next edge, then feeds len+1 words following vpat (1 after it ends).
  task automatic burst_body(input int r, input int len, input logic [15:0] vpat, input int vlen);
    int              words;
    int              k;
    logic            v;
    logic [NREQ-1:0] oh;
    wr_t             e;
    oh = NREQ'(1) << r;
    tick();
    checks++;
    if (gnt !== oh) begin
      failures++;
      $display("FAIL grant r=%0d got=%b exp=%b", r, gnt, oh);
    end
    req[r] = 1'b0;
    words = 0;
    k = 0;
    while (words < len + 1) begin
      v = (k < vlen) ? vpat[k] : 1'b1;
      req_valid[r] = v;
      if (v) begin
        req_data[r*DSIZE +: DSIZE] = data_seq;
        e.addr = m_wbin[ADDRSIZE-1:0];
        e.data = data_seq;
        e.ack  = oh;
        exp_q.push_back(e);
        data_seq++;
        m_wbin++;
        words++;
      end
      k++;
      tick();
      checks++;
      if (wptr !== gray(m_wbin)) begin
        failures++;
        $display("FAIL wptr got=%0d exp=%0d", wptr, gray(m_wbin));
      end
      if (words < len + 1) begin
        checks++;
        if (gnt !== oh) begin
          failures++;
          $display("FAIL gnt_hold got=%b exp=%b", gnt, oh);
        end
      end
    end
    req_valid[r] = 1'b0;
    checks++;
    if (gnt !== '0) begin
      failures++;
      $display("FAIL gnt_release got=%b exp=0000", gnt);
    end
    checks++;
    if (wfree !== m_free()) begin
      failures++;
      $display("FAIL wfree got=%0d exp=%0d", wfree, m_free());
    end
    checks++;
    if (wfull !== (m_free() == '0)) begin
      failures++;
      $display("FAIL wfull got=%b exp=%b", wfull, (m_free() == '0));
    end
  endtask

  task automatic run_burst(input int r, input int len, input logic [15:0] vpat, input int vlen);
    req_len[r*LENW +: LENW] = LENW'(len);
    req[r] = 1'b1;
    burst_body(r, len, vpat, vlen);
  endtask

  task automatic test_reset();
    wrst_n    = 1'b0;
    req       = '0;
    req_len   = '0;
    req_valid = '0;
    req_data  = '0;
    wq2_rptr  = '0;
    tick();
    tick();
    checks++;
    if (gnt !== '0 || req_ack !== '0 || winc !== 1'b0 || wptr !== '0 || waddr !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b ack=%b winc=%b wptr=%0d waddr=%0d exp all 0",
               gnt, req_ack, winc, wptr, waddr);
    end
    checks++;
    if (wfull !== 1'b0 || wfree !== DEPTH) begin
      failures++;
      $display("FAIL reset_space got wfull=%b wfree=%0d exp wfull=0 wfree=16", wfull, wfree);
    end
    wrst_n = 1'b1;
    m_wbin = '0;
    m_rbin = '0;
    tick();
    checks++;
    if (wfree !== DEPTH || gnt !== '0) begin
      failures++;
      $display("FAIL post_reset got wfree=%0d gnt=%b exp wfree=16 gnt=0000", wfree, gnt);
    end
  endtask

  task automatic test_basic();
    run_burst(0, 3, 16'h0000, 0);
    checks++;
    if (wfree !== 5'd12) begin
      failures++;
      $display("FAIL basic_wfree got=%0d exp=12", wfree);
    end
  endtask

  task automatic test_round_robin();
    int              r;
    logic [NREQ-1:0] oh;
    wr_t             e;
    do_reset();
    req_len   = '0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'hF;
    req       = 4'hF;
    for (int i = 0; i < 5; i++) begin
      r  = i % NREQ;
      oh = NREQ'(1) << r;
      tick();
      checks++;
      if (gnt !== oh) begin
        failures++;
        $display("FAIL rr_grant i=%0d got=%b exp=%b", i, gnt, oh);
      end
      e.addr = m_wbin[ADDRSIZE-1:0];
      e.data = 8'hA0 + 8'(r);
      e.ack  = oh;
      exp_q.push_back(e);
      m_wbin++;
      tick();
      if (i == 4) begin
        req       = '0;
        req_valid = '0;
      end
      checks++;
      if (gnt !== '0 || winc !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle i=%0d got gnt=%b winc=%b exp gnt=0000 winc=0", i, gnt, winc);
      end
      wq2_rptr = gray(m_wbin);
      m_rbin   = m_wbin;
    end
    tick();
    checks++;
    if (gnt !== '0 || wfree !== DEPTH) begin
      failures++;
      $display("FAIL rr_drained got gnt=%b wfree=%0d exp gnt=0000 wfree=16", gnt, wfree);
    end
  endtask

  task automatic test_head_of_line();
    do_reset();
    run_burst(1, 13, 16'h0000, 0);
    req_len[2*LENW +: LENW] = 4'd3;
    req_len[3*LENW +: LENW] = 4'd0;
    req[2] = 1'b1;
    req[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt !== '0 || wfree !== 5'd2) begin
        failures++;
        $display("FAIL hol_wait cycle=%0d got gnt=%b wfree=%0d exp gnt=0000 wfree=2", i, gnt, wfree);
      end
    end
    wq2_rptr = gray(5'd2);
    m_rbin   = 5'd2;
    req[3]   = 1'b0;
    burst_body(2, 3, 16'h0000, 0);
    checks++;
    if (wfull !== 1'b1 || wfree !== '0) begin
      failures++;
      $display("FAIL hol_full got wfull=%b wfree=%0d exp wfull=1 wfree=0", wfull, wfree);
    end
  endtask

  task automatic test_valid_gaps();
    int c0;
    do_reset();
    c0 = winc_count;
    run_burst(0, 3, 16'h0059, 7);
    checks++;
    if (winc_count - c0 !== 4) begin
      failures++;
      $display("FAIL gap_pulses got=%0d exp=4", winc_count - c0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_burst(0, 15, 16'h0000, 0);
    wq2_rptr = gray(5'd16);
    m_rbin   = 5'd16;
    run_burst(1, 13, 16'h0000, 0);
    wq2_rptr = gray(5'd28);
    m_rbin   = 5'd28;
    run_burst(2, 3, 16'h0000, 0);
    checks++;
    if (wptr !== 5'd3 || wfree !== 5'd10) begin
      failures++;
      $display("FAIL wrap got wptr=%0d wfree=%0d exp wptr=3 wfree=10", wptr, wfree);
    end
  endtask

  task automatic test_reset_mid_burst();
    wr_t e;
    do_reset();
    req_len[1*LENW +: LENW] = 4'd4;
    req[1] = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL mid_grant got=%b exp=0010", gnt);
    end
    req[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[1] = 1'b1;
      req_data[1*DSIZE +: DSIZE] = data_seq;
      e.addr = m_wbin[ADDRSIZE-1:0];
      e.data = data_seq;
      e.ack  = 4'b0010;
      exp_q.push_back(e);
      data_seq++;
      m_wbin++;
      tick();
    end
    wrst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || winc !== 1'b0 || wptr !== '0 || waddr !== '0 || req_ack !== '0) begin
      failures++;
      $display("FAIL mid_reset got gnt=%b winc=%b wptr=%0d waddr=%0d ack=%b exp all 0",
               gnt, winc, wptr, waddr, req_ack);
    end
    req_valid = '0;
    tick();
    wrst_n   = 1'b1;
    wq2_rptr = '0;
    m_wbin   = '0;
    m_rbin   = '0;
    tick();
    run_burst(3, 0, 16'h0000, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_head_of_line();
    test_valid_gaps();
    test_wrap();
    test_reset_mid_burst();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_writes got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
- Write-side scheduler for the async FIFO. Arbitrates up to NREQ requesters onto the single FIFO write port in the wclk domain.
- Owns the binary and Gray write pointers. Computes free space from the synchronized Gray read pointer (output of the read-to-write synchronizer).
- Grants a whole burst only when free space covers it, so a granted burst can never overflow the FIFO.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE.
- DSIZE, 8, data word width.
- NREQ, 4, number of requesters (2..8).
- LENW, 4, burst length field width; burst words = req_len+1; req_len+1 must be <= 2^ADDRSIZE.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  burst request per requester, level.
- req_len  in  NREQ*LENW  burst length minus one, requester i at [i*LENW +: LENW].
- req_valid  in  NREQ  data-valid per requester during its burst.
- req_data  in  NREQ*DSIZE  write data, requester i at [i*DSIZE +: DSIZE].
- gnt  out  NREQ  one-hot registered grant, held for the whole burst.
- req_ack  out  NREQ  per-requester pulse, word accepted this cycle.
- wq2_rptr  in  ADDRSIZE+1  read pointer, Gray, already synchronized into wclk.
- winc  out  1  memory write enable (combinational).
- waddr  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wdata  out  DSIZE  memory write data, muxed from the granted requester.
- wptr  out  ADDRSIZE+1  Gray write pointer, registered, to the write-to-read synchronizer.
- wfull  out  1  registered, 1 when free space is 0.
- wfree  out  ADDRSIZE+1  registered free-word count, 0..2^ADDRSIZE.

Behaviour:
- Reset (async, wrst_n=0):
  - wbin=0, wptr=0, gnt=0, req_ack=0, wfull=0, wfree=2^ADDRSIZE.
  - State=IDLE, round-robin pointer rr=0, burst counter=0.
  - Applies immediately, including mid-burst. The partial burst is abandoned; its words already written stay in memory.
- Space arithmetic (all ADDRSIZE+1 bits, modulo 2^(ADDRSIZE+1)):
  - rbin = gray2bin(wq2_rptr).
  - used = wbin_next - rbin.
  - free = 2^ADDRSIZE - used.
  - wfree and wfull are registered from wbin_next, so they are correct in the cycle after a write.
  - Pointer wrap-around comes from the modulo arithmetic; no special case.
- States:
  - IDLE:
    - Candidate = first asserted req scanning from index rr upward, wrapping.
    - If candidate c exists and free >= req_len[c]+1: next cycle gnt=onehot(c), cnt=req_len[c], state=BURST.
    - Else stay in IDLE. There is no skip to a smaller request: the candidate is held head-of-line so it cannot starve.
    - A candidate whose req drops while waiting is released; rescan next cycle.
  - BURST:
    - winc = req_valid[g] for granted g; req_ack[g] = winc; wdata = req_data[g].
    - Each write: wbin+=1, wptr=bin2gray(wbin+1), both registered.
    - Gaps in req_valid stall the burst with no timeout.
    - A write when cnt==0 is the last word: next cycle gnt=0, rr=g+1 mod NREQ, state=IDLE. Otherwise cnt-=1.
    - req, req_len and req of other requesters are ignored during BURST. Deasserting req mid-burst does not end the burst.
- Latency:
  - req asserted at cycle n with space available → gnt at n+1 → first write earliest at n+1.
  - Back-to-back bursts leave 1 idle cycle, the IDLE arbitration cycle.
- Safety:
  - winc is never 1 outside BURST.
  - Because space is reserved at grant, winc is never 1 while wfull=1.
  - A concurrent read only increases free; the reservation remains valid.

Test Plan:
- Empty FIFO (ADDRSIZE=4), req[0]=1, req_len=3, req_valid=1 continuous → gnt=0001 one cycle later; 4 writes at waddr 0..3; wptr goes 1,3,2,6 (Gray); wfree=12; gnt=0.
- req=1111 held, all req_len=0, read side draining → grants rotate 0,1,2,3,0; each grant writes 1 word; one IDLE cycle between bursts.
- wbin=14, rptr=0 (free=2), req[2] with req_len=3 → no grant while rptr is unchanged. Raise wq2_rptr to Gray(2) → grant the next cycle; 4 writes; wfull=1 after the last write.
- During a 4-word burst, toggle req_valid as 1,0,0,1,1,0,1 → exactly 4 winc/req_ack pulses; gnt held until the 4th.
- Pointer wrap: start with wbin=30, rbin=28 and write 4 words → wbin wraps to 2; wptr=Gray(2)=3; wfree stays correct (16-6=10).
- Assert wrst_n=0 after the 2nd word of a 5-word burst → gnt, winc, wptr and wbin go to 0 immediately; after release, a new request is granted starting at waddr 0.
